// File: rtl/noc_flit_fifo_rd.sv
// Show-ahead flit FIFO for the NoC network interface: active-low push with
// write-through bypass when empty, active-low pop, occupancy flags and sticky error.
module noc_flit_fifo_rd #(
    parameter int DSIZE  = 8,
    parameter int AWIDTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_n,
    input  logic [DSIZE-1:0]  wdata,
    input  logic              rd_en_n,
    output logic [DSIZE-1:0]  rdata,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [AWIDTH:0]   count,
    output logic              err
);

    localparam int DEPTH = 2 ** AWIDTH;
    localparam logic [AWIDTH:0] FULL_COUNT = {1'b1, {AWIDTH{1'b0}}};

    logic [DSIZE-1:0]  mem [DEPTH];
    logic [AWIDTH-1:0] rp;
    logic [AWIDTH-1:0] wp;
    logic [AWIDTH:0]   count_next;

    logic push;
    logic pop;
    logic do_write;
    logic do_read;
    logic bad_access;

    assign push = !wr_en_n;
    assign pop  = !rd_en_n;

    // A push with a pop on an empty FIFO is the pure bypass case and never touches storage.
    assign do_write   = push && ((!pop && !full) || (pop && !empty));
    assign do_read    = pop && !empty;
    assign bad_access = (push && !pop && full) || (pop && !push && empty);

    always_comb begin
        count_next = count;
        if (do_write && !do_read)
            count_next = count + (AWIDTH+1)'(1);
        else if (do_read && !do_write)
            count_next = count - (AWIDTH+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rp    <= '0;
            wp    <= '0;
            count <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
            err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (do_write) begin
                mem[wp] <= wdata;
                wp      <= wp + AWIDTH'(1);
            end
            if (do_read)
                rp <= rp + AWIDTH'(1);
            if (bad_access)
                err <= 1'b1;
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == FULL_COUNT);
        end
    end

    // Only wr_en_n/wdata reach the outputs combinationally; the pop side is purely registered.
    always_comb begin
        if (!empty)
            rdata = mem[rp];
        else if (push)
            rdata = wdata;
        else
            rdata = '0;
    end

    assign rd_valid = !empty || push;

endmodule

// File: doc/noc_flit_fifo_rd.md
# noc_flit_fifo_rd

Read-side counterpart to the NI's write-through storage element: a small show-ahead flit FIFO for the NoC network interface. The write port keeps the active-low write-enable and write-through behaviour of the storage element, so a flit written into an empty FIFO is readable in the same cycle. The block adds the read side: an active-low pop, head-of-queue presentation, occupancy flags and error reporting. It sits between the NI packetiser (writer) and the link/switch input port (reader).

## Interface
- DSIZE, 8, flit width in bits
- AWIDTH, 2, pointer width; DEPTH = 2**AWIDTH entries (AWIDTH >= 1)
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en_n  in  1  active-low push
- wdata  in  DSIZE  push data
- rd_en_n  in  1  active-low pop of the current head
- rdata  out  DSIZE  head flit (show-ahead), or the bypassed wdata
- rd_valid  out  1  rdata is meaningful; equals !empty | !wr_en_n
- empty  out  1  registered: storage holds 0 entries
- full  out  1  registered: storage holds DEPTH entries
- count  out  AWIDTH+1  registered occupancy, 0..DEPTH
- err  out  1  sticky: an overflow or underflow was attempted

## Operation
- Storage: DEPTH x DSIZE array, read pointer rp and write pointer wp (AWIDTH bits each, wrap modulo DEPTH), plus count.
- rdata mux:
  - empty=0: mem[rp].
  - empty=1 and wr_en_n=0: wdata (write-through bypass).
  - otherwise: all zeros.
- Each cycle, with W = !wr_en_n and R = !rd_en_n:
  - W, !R, !full: mem[wp] <= wdata; wp++; count++.
  - W, !R, full: write dropped; err <= 1.
  - !W, R, !empty: rp++; count--.
  - !W, R, empty: pop ignored; err <= 1.
  - W, R, !empty (including full): mem[wp] <= wdata; wp++; rp++; count unchanged. Simultaneous push and pop on full is legal.
  - W, R, empty: bypass; the flit passes wdata to rdata and is consumed. No storage write, pointers and count unchanged, no error.
  - W, !R, empty: stored normally. The bypassed value on rdata is not consumed.
- Flags derive from the next count: empty <= (count_next == 0), full <= (count_next == DEPTH).
- err stays high until reset.
- Reset (asynchronous, any time, including mid-burst):
  - rp = wp = 0, count = 0, empty = 1, full = 0, err = 0, array cleared to 0.
  - Outputs during and after reset: rdata = 0 unless bypass is active, rd_valid = !wr_en_n.
  - In-flight flits are discarded.

## Timing
- Push-to-read latency:
  - 0 cycles when the FIFO is empty (combinational bypass).
  - Otherwise the flit reaches the head after the entries ahead of it are popped; rdata updates the cycle after the pop edge.
- Pop takes effect at the rising edge where rd_en_n=0. The next head appears on rdata after that edge.
- empty, full and count update at the same edge as the push or pop that changes them. No combinational path from rd_en_n to any output.
- Combinational paths to outputs: wr_en_n and wdata to rdata and rd_valid. This matches the storage element's write-through path.
- Throughput: one push and one pop per cycle sustained, at any occupancy.

## Test plan
- Reset then idle: assert rst mid-cycle, release, hold wr_en_n = rd_en_n = 1 → empty=1, full=0, count=0, err=0, rdata=0, rd_valid=0. Reset must take effect before the next clock edge.
- Bypass: empty FIFO, wr_en_n=0, wdata=8'hA5, rd_en_n=0 for one cycle → rdata=8'hA5 and rd_valid=1 in the same cycle; afterwards count=0, empty=1, err=0.
- Fill and overflow (AWIDTH=2): push 8'h01..8'h04 → full=1, count=4, rdata=8'h01. Push 8'h05 with no pop → err=1, contents unchanged. Then pop four times → rdata sequence 01, 02, 03, 04, then empty=1.
- Full with simultaneous push/pop: full with 01..04, wr_en_n=0 wdata=8'h05, rd_en_n=0 → count stays 4, err stays 0, next rdata=8'h02. Draining yields 02, 03, 04, 05, which checks pointer wrap-around.
- Underflow: empty FIFO, rd_en_n=0, wr_en_n=1 → err=1, count=0, pointers unchanged. A subsequent push of 8'h3C is read back correctly.
- Reset mid-operation: 3 entries stored, assert rst → count=0, empty=1, err=0 immediately. The next push of 8'h77 appears at rdata via bypass and is the only entry.
